dmac_ctrl_arbiter: RTL and testbench

Round-robin arbiter that shares the single DMA-controller control target port among NB_REQ peripheral-bus requesters (cluster cores, FC, HW accelerators). It forwards one request per cycle onto the controller port and records the granted requester index in an in-order tracking FIFO. Responses are routed back to their originators from that FIFO. It sits between the cluster peripheral interconnect and one control slot of the DMA controller wrapper.

---
 rtl/dmac_ctrl_pkg.sv | 28 ++
 rtl/dmac_ctrl_track_fifo.sv | 70 +++++++
 rtl/dmac_ctrl_arbiter.sv | 162 ++++++++++++++++
 tb/tb_dmac_ctrl_arbiter.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmac_ctrl_pkg.sv
// Shared types and helpers for the DMA control-port arbiter.
// Request/response bundles plus the requester index width helper.
package dmac_ctrl_pkg;

  localparam int DMAC_ADDR_W = 32;
  localparam int DMAC_DATA_W = 32;
  localparam int DMAC_BE_W   = DMAC_DATA_W / 8;
  localparam int DMAC_ID_W   = 1;

  typedef struct packed {
    logic [DMAC_ADDR_W-1:0] add;
    logic                   wen;
    logic [DMAC_DATA_W-1:0] wdata;
    logic [DMAC_BE_W-1:0]   be;
    logic [DMAC_ID_W-1:0]   id;
  } dmac_req_t;

  typedef struct packed {
    logic [DMAC_DATA_W-1:0] rdata;
    logic                   opc;
    logic [DMAC_ID_W-1:0]   id;
  } dmac_rsp_t;

  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dmac_ctrl_track_fifo.sv
// In-order tracking FIFO of granted requester indices.
// Ports: push/pop/data in; head, full, empty, count out.
module dmac_ctrl_track_fifo
  import dmac_ctrl_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 3
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [W-1:0]           data_i,
  output logic [W-1:0]           head_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push_i) begin
      mem_d[wr_q] = data_i;
      wr_d        = wr_q + 1'b1;
    end
    if (pop_i) begin
      rd_d = rd_q + 1'b1;
    end
    case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: entries are only read below count.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign head_o  = mem_q[rd_q];
  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;

endmodule

// File: rtl/dmac_ctrl_arbiter.sv
// Round-robin arbiter sharing one DMA control port among NB_REQ
// requesters; responses routed back in order via tracking FIFO.
module dmac_ctrl_arbiter
  import dmac_ctrl_pkg::*;
#(
  parameter int NB_REQ          = 8,
  parameter int ADDR_WIDTH      = DMAC_ADDR_W,
  parameter int DATA_WIDTH      = DMAC_DATA_W,
  parameter int BE_WIDTH        = DATA_WIDTH / 8,
  parameter int ID_WIDTH        = DMAC_ID_W,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NB_REQ-1:0]            req_i,
  input  logic [NB_REQ*ADDR_WIDTH-1:0] add_i,
  input  logic [NB_REQ-1:0]            wen_i,
  input  logic [NB_REQ*DATA_WIDTH-1:0] wdata_i,
  input  logic [NB_REQ*BE_WIDTH-1:0]   be_i,
  input  logic [NB_REQ*ID_WIDTH-1:0]   id_i,
  output logic [NB_REQ-1:0]            gnt_o,
  output logic [NB_REQ-1:0]            r_valid_o,
  output logic [DATA_WIDTH-1:0]        r_rdata_o,
  output logic                         r_opc_o,
  output logic [ID_WIDTH-1:0]          r_id_o,
  output logic                         m_req_o,
  output logic [ADDR_WIDTH-1:0]        m_add_o,
  output logic                         m_wen_o,
  output logic [DATA_WIDTH-1:0]        m_wdata_o,
  output logic [BE_WIDTH-1:0]          m_be_o,
  output logic [ID_WIDTH-1:0]          m_id_o,
  input  logic                         m_gnt_i,
  input  logic                         m_r_valid_i,
  input  logic [DATA_WIDTH-1:0]        m_r_rdata_i,
  input  logic                         m_r_opc_i,
  input  logic [ID_WIDTH-1:0]          m_r_id_i,
  output logic                         busy_o,
  output logic                         err_o
);

  localparam int IDX_W = idx_width(NB_REQ);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

  logic [IDX_W-1:0] rr_q, rr_d;
  logic             err_q, err_d;
  logic [IDX_W-1:0] win;
  logic             any;
  logic             pop;
  logic             can_push;
  logic             m_req;
  logic             accept;
  logic [IDX_W-1:0] head;
  logic             full;
  logic             empty;
  logic [CNT_W-1:0] count;
  dmac_req_t        win_req;
  dmac_rsp_t        rsp;

  // First asserted request at or above rr_q, wrapping to 0.
  always_comb begin
    int j;
    win = '0;
    any = 1'b0;
    j   = 0;
    for (int k = 0; k < NB_REQ; k++) begin
      j = int'(rr_q) + k;
      if (j >= NB_REQ) j = j - NB_REQ;
      if (!any && req_i[j]) begin
        any = 1'b1;
        win = IDX_W'(j);
      end
    end
  end

  always_comb begin
    win_req.add   = add_i[int'(win)*ADDR_WIDTH +: ADDR_WIDTH];
    win_req.wen   = wen_i[win];
    win_req.wdata = wdata_i[int'(win)*DATA_WIDTH +: DATA_WIDTH];
    win_req.be    = be_i[int'(win)*BE_WIDTH +: BE_WIDTH];
    win_req.id    = id_i[int'(win)*ID_WIDTH +: ID_WIDTH];
  end

  assign rsp.rdata = m_r_rdata_i;
  assign rsp.opc   = m_r_opc_i;
  assign rsp.id    = m_r_id_i;

  // A pop in the same cycle frees the slot a full FIFO needs.
  assign pop      = m_r_valid_i & ~empty & ~rst_i;
  assign can_push = ~full | pop;
  assign m_req    = any & can_push & ~rst_i;
  assign accept   = m_req & m_gnt_i;

  always_comb begin
    rr_d = rr_q;
    if (accept) begin
      rr_d = (win == IDX_W'(NB_REQ - 1)) ? '0 : win + 1'b1;
    end
  end

  // Stray response: nothing tracked to route it to.
  assign err_d = err_q | (m_r_valid_i & empty);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_q  <= '0;
      err_q <= 1'b0;
    end else begin
      rr_q  <= rr_d;
      err_q <= err_d;
    end
  end

  dmac_ctrl_track_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .W     (IDX_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (accept),
    .pop_i   (pop),
    .data_i  (win),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  always_comb begin
    gnt_o     = '0;
    m_req_o   = m_req;
    m_add_o   = '0;
    m_wen_o   = 1'b0;
    m_wdata_o = '0;
    m_be_o    = '0;
    m_id_o    = '0;
    if (accept) gnt_o[win] = 1'b1;
    if (m_req) begin
      m_add_o   = win_req.add;
      m_wen_o   = win_req.wen;
      m_wdata_o = win_req.wdata;
      m_be_o    = win_req.be;
      m_id_o    = win_req.id;
    end
  end

  always_comb begin
    r_valid_o = '0;
    r_rdata_o = '0;
    r_opc_o   = 1'b0;
    r_id_o    = '0;
    if (pop) begin
      r_valid_o[head] = 1'b1;
      r_rdata_o       = rsp.rdata;
      r_opc_o         = rsp.opc;
      r_id_o          = rsp.id;
    end
  end

  assign busy_o = (count != '0) & ~rst_i;
  assign err_o  = err_q & ~rst_i;

endmodule

// File: tb/tb_dmac_ctrl_arbiter.sv
// Scoreboard bench for dmac_ctrl_arbiter: directed scenarios plus
// randomized traffic against a transaction-level reference model.
module tb_dmac_ctrl_arbiter;

  localparam int NB   = 8;
  localparam int MAXO = 4;

  logic          clk;
  logic          rst_i;
  logic [NB-1:0] req_i;
  logic [NB*32-1:0] add_i;
  logic [NB-1:0] wen_i;
  logic [NB*32-1:0] wdata_i;
  logic [NB*4-1:0]  be_i;
  logic [NB-1:0] id_i;
  logic [NB-1:0] gnt_o;
  logic [NB-1:0] r_valid_o;
  logic [31:0]   r_rdata_o;
  logic          r_opc_o;
  logic          r_id_o;
  logic          m_req_o;
  logic [31:0]   m_add_o;
  logic          m_wen_o;
  logic [31:0]   m_wdata_o;
  logic [3:0]    m_be_o;
  logic          m_id_o;
  logic          m_gnt_i;
  logic          m_r_valid_i;
  logic [31:0]   m_r_rdata_i;
  logic          m_r_opc_i;
  logic          m_r_id_i;
  logic          busy_o;
  logic          err_o;

  dmac_ctrl_arbiter #(
    .NB_REQ          (NB),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .req_i       (req_i),
    .add_i       (add_i),
    .wen_i       (wen_i),
    .wdata_i     (wdata_i),
    .be_i        (be_i),
    .id_i        (id_i),
    .gnt_o       (gnt_o),
    .r_valid_o   (r_valid_o),
    .r_rdata_o   (r_rdata_o),
    .r_opc_o     (r_opc_o),
    .r_id_o      (r_id_o),
    .m_req_o     (m_req_o),
    .m_add_o     (m_add_o),
    .m_wen_o     (m_wen_o),
    .m_wdata_o   (m_wdata_o),
    .m_be_o      (m_be_o),
    .m_id_o      (m_id_o),
    .m_gnt_i     (m_gnt_i),
    .m_r_valid_i (m_r_valid_i),
    .m_r_rdata_i (m_r_rdata_i),
    .m_r_opc_i   (m_r_opc_i),
    .m_r_id_i    (m_r_id_i),
    .busy_o      (busy_o),
    .err_o       (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        mreq;
    logic        busy;
    logic        err;
    logic [31:0] add;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        id;
  } sexp_t;

  typedef struct packed {
    logic [NB-1:0] rv;
    logic [31:0]   rdata;
    logic          opc;
    logic          id;
  } rexp_t;

  sexp_t         sq[$];
  logic [NB-1:0] gq[$];
  rexp_t         rq[$];
  int            gnt_log[$];

  int checks = 0;
  int errors = 0;

  // Requester state: a pending request holds its fields until granted.
  bit          rq_v[NB];
  logic [31:0] rq_add[NB];
  logic        rq_wen[NB];
  logic [31:0] rq_wdata[NB];
  logic [3:0]  rq_be[NB];
  logic        rq_id[NB];

  // Stimulus controls for the next cycle.
  bit rst, gnt, rv;

  // Reference model: rr pointer, queue of outstanding requesters.
  int outq[$];
  int rr;
  bit merr;

  task automatic chk(input string nm, input logic [127:0] a,
                     input logic [127:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  task automatic raise(input int i);
    rq_v[i]     = 1'b1;
    rq_add[i]   = $urandom;
    rq_wen[i]   = 1'($urandom);
    rq_wdata[i] = $urandom;
    rq_be[i]    = 4'($urandom);
    rq_id[i]    = 1'($urandom);
  endtask

  task automatic tick();
    sexp_t s;
    rexp_t r;
    int    cnt, w, j;
    bit    any, pop, mreq, acc;
    @(negedge clk);
    for (int i = 0; i < NB; i++) begin
      req_i[i]             = rq_v[i];
      add_i[i*32 +: 32]    = rq_add[i];
      wen_i[i]             = rq_wen[i];
      wdata_i[i*32 +: 32]  = rq_wdata[i];
      be_i[i*4 +: 4]       = rq_be[i];
      id_i[i]              = rq_id[i];
    end
    rst_i       = rst;
    m_gnt_i     = gnt;
    m_r_valid_i = rv;
    m_r_rdata_i = $urandom;
    m_r_opc_i   = 1'($urandom);
    m_r_id_i    = 1'($urandom);
    s = '0;
    if (rst) begin
      sq.push_back(s);
      outq.delete();
      rr   = 0;
      merr = 1'b0;
    end else begin
      cnt = outq.size();
      any = 1'b0;
      w   = 0;
      for (int k = 0; k < NB; k++) begin
        j = (rr + k) % NB;
        if (!any && rq_v[j]) begin
          any = 1'b1;
          w   = j;
        end
      end
      pop  = rv && cnt > 0;
      mreq = any && (cnt < MAXO || pop);
      acc  = mreq && gnt;
      s.mreq = mreq;
      s.busy = cnt != 0;
      s.err  = merr;
      if (mreq) begin
        s.add   = rq_add[w];
        s.wen   = rq_wen[w];
        s.wdata = rq_wdata[w];
        s.be    = rq_be[w];
        s.id    = rq_id[w];
      end
      sq.push_back(s);
      if (acc) gq.push_back(NB'(1 << w));
      if (pop) begin
        r.rv    = NB'(1 << outq[0]);
        r.rdata = m_r_rdata_i;
        r.opc   = m_r_opc_i;
        r.id    = m_r_id_i;
        rq.push_back(r);
        void'(outq.pop_front());
      end
      if (rv && cnt == 0) merr = 1'b1;
      if (acc) begin
        outq.push_back(w);
        rr = (w + 1) % NB;
        rq_v[w] = 1'b0;
      end
    end
  endtask

  // Monitor: samples 2 time units after each falling edge.
  always @(negedge clk) begin
    sexp_t         s;
    logic [NB-1:0] e;
    rexp_t         r;
    #2;
    if (sq.size() > 0) begin
      s = sq.pop_front();
      chk("m_req", m_req_o, s.mreq);
      chk("busy", busy_o, s.busy);
      chk("err", err_o, s.err);
      chk("m_fields",
          {m_add_o, m_wen_o, m_wdata_o, m_be_o, m_id_o},
          {s.add, s.wen, s.wdata, s.be, s.id});
    end
    if (gnt_o != '0 || gq.size() > 0) begin
      e = (gq.size() > 0) ? gq.pop_front() : '0;
      chk("gnt", gnt_o, e);
      for (int i = 0; i < NB; i++)
        if (gnt_o[i]) gnt_log.push_back(i);
    end
    if (r_valid_o != '0 || rq.size() > 0) begin
      r = (rq.size() > 0) ? rq.pop_front() : '0;
      chk("resp", {r_valid_o, r_rdata_o, r_opc_o, r_id_o}, r);
    end else begin
      chk("resp_idle", {r_rdata_o, r_opc_o, r_id_o}, '0);
    end
  end

  task automatic drain();
    gnt = 1'b0;
    for (int n = 0; n < 16 && outq.size() > 0; n++) begin
      rv = 1'b1;
      tick();
    end
    rv = 1'b0;
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < NB; i++) rq_v[i] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    req_i = '0; add_i = '0; wen_i = '0; wdata_i = '0;
    be_i = '0; id_i = '0; rst_i = 1'b1; m_gnt_i = 1'b0;
    m_r_valid_i = 1'b0; m_r_rdata_i = '0; m_r_opc_i = 1'b0;
    m_r_id_i = 1'b0;
    clear_reqs();
    rr = 0; merr = 1'b0;
    rst = 1'b1; gnt = 1'b0; rv = 1'b0;
    tick(); tick();
    #2 chk("rst_out", {gnt_o, r_valid_o, m_req_o, busy_o, err_o}, '0);
    rst = 1'b0;

    // Single write from requester 3.
    raise(3); rq_wen[3] = 1'b0; gnt = 1'b1;
    tick();
    #2 chk("single_gnt", gnt_o, 8'h08);
    chk("single_add", m_add_o, rq_add[3]);
    gnt = 1'b0; rv = 1'b1;
    tick();
    #2 chk("single_rv", r_valid_o, 8'h08);
    rv = 1'b0;
    tick();
    #2 chk("single_busy", busy_o, 1'b0);

    // Contention between requesters 0 and 2.
    n0 = gnt_log.size();
    raise(0); raise(2); gnt = 1'b1;
    for (int c = 0; c < 4; c++) begin
      rv = outq.size() > 0;
      tick();
      if (!rq_v[0]) raise(0);
      if (!rq_v[2]) raise(2);
    end
    clear_reqs();
    drain();
    #2;
    if (gnt_log.size() >= n0 + 4) begin
      chk("cont_0", gnt_log[n0],   0);
      chk("cont_1", gnt_log[n0+1], 2);
      chk("cont_2", gnt_log[n0+2], 0);
      chk("cont_3", gnt_log[n0+3], 2);
    end else begin
      chk("cont_cnt", gnt_log.size() - n0, 4);
    end

    // Backpressure: controller withholds grant.
    raise(1); raise(2); gnt = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      #2 chk("bp_hold", gnt_o, 8'h00);
    end
    gnt = 1'b1;
    tick();
    #2 chk("bp_first", gnt_o, 8'h02);
    tick();
    #2 chk("bp_second", gnt_o, 8'h04);
    drain();

    // Fill the tracking FIFO.
    gnt = 1'b1;
    for (int c = 0; c < MAXO; c++) begin
      raise(5);
      tick();
    end
    raise(5);
    tick();
    #2 chk("full_mreq", m_req_o, 1'b0);
    chk("full_gnt", gnt_o, 8'h00);
    rv = 1'b1;
    tick();
    #2 chk("full_pop_gnt", gnt_o, 8'h20);
    chk("full_pop_rv", r_valid_o, 8'h20);
    rv = 1'b0; gnt = 1'b0;
    tick();
    #2 chk("full_busy", busy_o, 1'b1);
    drain();

    // Randomized traffic.
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < NB; i++)
        if (!rq_v[i] && ($urandom % 3 == 0)) raise(i);
      gnt = ($urandom % 4) != 0;
      rv  = outq.size() > 0 && ($urandom % 2 == 1);
      tick();
    end
    clear_reqs();
    drain();
    tick();

    // Stray response with nothing outstanding.
    rv = 1'b1;
    tick();
    #2 chk("stray_rv", r_valid_o, 8'h00);
    rv = 1'b0;
    tick();
    #2 chk("stray_err", err_o, 1'b1);
    tick(); tick();
    #2 chk("stray_sticky", err_o, 1'b1);

    // Reset with two transactions in flight.
    gnt = 1'b1;
    raise(6); tick();
    raise(4); tick();
    gnt = 1'b0;
    raise(3); raise(5);
    rst = 1'b1;
    tick();
    #2 chk("mid_rst", {gnt_o, r_valid_o, m_req_o, busy_o, err_o,
                       m_add_o, r_rdata_o}, '0);
    rst = 1'b0; gnt = 1'b1;
    tick();
    #2 chk("post_rst_gnt", gnt_o, 8'h08);
    chk("post_rst_err", err_o, 1'b0);
    clear_reqs();
    drain();
    tick();
    #5;
    if (sq.size() != 0 || gq.size() != 0 || rq.size() != 0)
      chk("sb_empty", sq.size() + gq.size() + rq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
